// File: rtl/bcd2binary_seq_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
//   Shared definitions for the sequential packed-BCD to binary converter:
//   FSM state encoding, BCD digit constants and the constant function that
//   sizes the shift chain (number of conversion cycles) from the digit count.
// ---------------------------------------------------------------------------
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } bcd_state_e;

    localparam int BCD_DIGIT_W   = 4;
    localparam int BCD_MAX_DIGIT = 9;

    // Number of binary bits needed to hold any DIGITS-digit decimal value,
    // i.e. clog2(10**digits). This is also the number of right shifts the
    // reverse double-dabble needs to drain the BCD register completely.
    function automatic int calc_shifts(input int digits);
        longint unsigned span;
        int              bits;
        span = 64'd1;
        for (int i = 0; i < digits; i++) begin
            span = span * 64'd10;
        end
        bits = 0;
        for (int b = 0; b < 64; b++) begin
            if ((64'd1 << b) < span) begin
                bits = b + 1;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/bcd2binary_seq_if.sv
// ---------------------------------------------------------------------------
// bcd2binary_seq_if
//   Handshake bundle for the BCD to binary converter.
//   Upstream side : in_valid, in_ready, bcd_in (packed BCD, digit 0 in [3:0])
//   Downstream    : out_valid, out_ready, bin_out, ovf, err_digit
//   modport master : the producer/consumer environment around the converter
//   modport slave  : the converter itself
// ---------------------------------------------------------------------------
interface bcd2binary_seq_if #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [BIN_W-1:0]      bin_out;
    logic                  ovf;
    logic                  err_digit;

    modport master (
        output in_valid,
        output bcd_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  bin_out,
        input  ovf,
        input  err_digit
    );

    modport slave (
        input  in_valid,
        input  bcd_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output bin_out,
        output ovf,
        output err_digit
    );
endinterface

// File: rtl/bcd2binary_seq_digit_adj.sv
// ---------------------------------------------------------------------------
// bcd_digit_adj
//   Per-digit correction step of the reverse double-dabble. After a right
//   shift, a digit that received a 1 into its MSB from the digit above holds
//   (value + 8); the correct contribution is half of ten, i.e. +5, so 3 is
//   subtracted from any digit >= 8.
//   Ports: digit_in  (4 bits) shifted digit
//          digit_out (4 bits) corrected digit
// ---------------------------------------------------------------------------
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_in,
    output logic [BCD_DIGIT_W-1:0] digit_out
);
    localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESH = BCD_DIGIT_W'(8);
    localparam logic [BCD_DIGIT_W-1:0] ADJ_SUB    = BCD_DIGIT_W'(3);

    assign digit_out = (digit_in >= ADJ_THRESH) ? (digit_in - ADJ_SUB) : digit_in;
endmodule

// File: rtl/bcd2binary_seq.sv
// ---------------------------------------------------------------------------
// bcd2binary_seq
//   Sequential packed-BCD to binary converter (reverse double-dabble).
//   One bit is shifted out of the BCD register into the binary register per
//   cycle; each BCD digit is then corrected by bcd_digit_adj. SHIFTS cycles
//   convert a full DIGITS-digit operand.
//
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous active-high reset
//     bus    bcd2binary_seq_if.slave:
//              in_valid/in_ready/bcd_in      operand handshake
//              out_valid/out_ready/bin_out   result handshake
//              ovf        result does not fit in BIN_W bits
//              err_digit  an input nibble was greater than 9
//
//   Build option: BCD2BIN_SATURATE_EN
//     defined   : overflowing results read as all ones on bin_out
//     undefined : overflowing results are truncated to the low BIN_W bits
// ---------------------------------------------------------------------------
module bcd2binary_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    bcd2binary_seq_if.slave  bus
);
    localparam int SHIFTS = calc_shifts(DIGITS);
    localparam int BCD_W  = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W  = $clog2(SHIFTS + 1);
    localparam int RES_W  = (SHIFTS > BIN_W) ? SHIFTS : BIN_W;

    bcd_state_e          state_reg;
    logic [BCD_W-1:0]    bcd_reg;
    logic [SHIFTS-1:0]   bin_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                in_ready_reg;
    logic                out_valid_reg;
    logic [BIN_W-1:0]    bin_out_reg;
    logic                ovf_reg;
    logic                err_digit_reg;

    logic [BCD_W-1:0]    bcd_shift;
    logic [BCD_W-1:0]    bcd_next;
    logic [SHIFTS-1:0]   bin_next;
    logic [DIGITS-1:0]   digit_bad;
    logic                input_bad;
    logic [RES_W-1:0]    result_ext;
    logic                res_ovf;
    logic [BIN_W-1:0]    res_trunc;
    logic [BIN_W-1:0]    res_out;

    // {bcd_reg, bin_reg} shifted right by one as a single long register.
    assign bcd_shift = bcd_reg >> 1;
    assign bin_next  = {bcd_reg[0], bin_reg[SHIFTS-1:1]};

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_digit_adj u_adj (
                .digit_in  (bcd_shift[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .digit_out (bcd_next[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
            assign digit_bad[gi] =
                (bus.bcd_in[gi*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_DIGIT_W'(BCD_MAX_DIGIT));
        end
    endgenerate

    assign input_bad = |digit_bad;

    // The result registers are loaded on the same edge as the final shift,
    // so they are fed from bin_next rather than bin_reg. Widening to RES_W
    // keeps the overflow test valid even if SHIFTS <= BIN_W.
    assign result_ext = RES_W'(bin_next);
    assign res_ovf    = (result_ext >> BIN_W) != '0;
    assign res_trunc  = result_ext[BIN_W-1:0];

`ifdef BCD2BIN_SATURATE_EN
    assign res_out = res_ovf ? '1 : res_trunc;
`else
    assign res_out = res_trunc;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            bcd_reg       <= '0;
            bin_reg       <= '0;
            cnt_reg       <= '0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            bin_out_reg   <= '0;
            ovf_reg       <= 1'b0;
            err_digit_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_ready_reg && bus.in_valid) begin
                        bcd_reg      <= bus.bcd_in;
                        bin_reg      <= '0;
                        cnt_reg      <= CNT_W'(SHIFTS);
                        in_ready_reg <= 1'b0;
                        if (input_bad) begin
                            // Invalid digit: skip conversion, report at once.
                            err_digit_reg <= 1'b1;
                            bin_out_reg   <= '0;
                            ovf_reg       <= 1'b0;
                            out_valid_reg <= 1'b1;
                            state_reg     <= DONE;
                        end else begin
                            state_reg <= CONV;
                        end
                    end else begin
                        // Raises in_ready the first cycle after reset too.
                        in_ready_reg <= 1'b1;
                    end
                end

                CONV: begin
                    bcd_reg <= bcd_next;
                    bin_reg <= bin_next;
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        bin_out_reg   <= res_out;
                        ovf_reg       <= res_ovf;
                        err_digit_reg <= 1'b0;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end

                DONE: begin
                    // Outputs hold until the consumer takes the result.
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end

                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b0;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.bin_out   = bin_out_reg;
    assign bus.ovf       = ovf_reg;
    assign bus.err_digit = err_digit_reg;

endmodule

// File: tb/tb_bcd2binary_seq.sv
// ---------------------------------------------------------------------------
// tb_bcd2binary_seq
//   Directed bench for bcd2binary_seq (DIGITS=3, BIN_W=8). Inputs are driven
//   and outputs sampled on the falling clock edge. Latency is counted in
//   rising edges including the accepting edge.
// ---------------------------------------------------------------------------
module tb_bcd2binary_seq;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    bcd2binary_seq_if #(.DIGITS(3), .BIN_W(8)) bus ();

    bcd2binary_seq #(.DIGITS(3), .BIN_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef BCD2BIN_SATURATE_EN
    localparam logic [7:0] EXP_256 = 8'hFF;
    localparam logic [7:0] EXP_999 = 8'hFF;
`else
    localparam logic [7:0] EXP_256 = 8'd0;
    localparam logic [7:0] EXP_999 = 8'd231;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One full transaction with out_ready held high.
    task automatic run_conv(input logic [11:0] bcd, input logic [7:0] exp_bin,
                            input logic exp_ovf, input logic exp_err, input int exp_lat);
        int n;
        int lat;
        bus.out_ready = 1'b1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(n < 20), 32'd1);
        bus.in_valid = 1'b1;
        bus.bcd_in   = bcd;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.bcd_in   = 12'hFFF;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("bin_out", 32'(bus.bin_out), 32'(exp_bin));
        check("ovf", 32'(bus.ovf), 32'(exp_ovf));
        check("err_digit", 32'(bus.err_digit), 32'(exp_err));
        $display("conv bcd=%h bin_out=%0d ovf=%0b err_digit=%0b latency=%0d",
                 bcd, bus.bin_out, bus.ovf, bus.err_digit, lat);
        @(negedge clk);
        check("out_valid_clear", 32'(bus.out_valid), 32'd0);
        check("in_ready_back", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        int seen;
        bus.in_valid  = 1'b0;
        bus.bcd_in    = 12'h000;
        bus.out_ready = 1'b1;

        // Reset state.
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_bin_out", 32'(bus.bin_out), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        check("rst_err", 32'(bus.err_digit), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(bus.in_ready), 32'd1);

        // Main function and boundaries.
        run_conv(12'h251, 8'd251, 1'b0, 1'b0, 11);
        run_conv(12'h000, 8'd0,   1'b0, 1'b0, 11);
        run_conv(12'h001, 8'd1,   1'b0, 1'b0, 11);
        run_conv(12'h255, 8'd255, 1'b0, 1'b0, 11);
        run_conv(12'h100, 8'd100, 1'b0, 1'b0, 11);
        run_conv(12'h256, EXP_256, 1'b1, 1'b0, 11);
        run_conv(12'h999, EXP_999, 1'b1, 1'b0, 11);
        run_conv(12'h1A2, 8'd0,   1'b0, 1'b1, 1);

        // Backpressure: result must hold, new operands ignored.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.bcd_in    = 12'h042;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("bp_latency", 32'(lat), 32'd11);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.bcd_in   = 12'h777;
            @(negedge clk);
            check("bp_bin_out", 32'(bus.bin_out), 32'd42);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(bus.out_valid), 32'd0);
        check("bp_release_ready", 32'(bus.in_ready), 32'd1);
        $display("backpressure bcd=042 bin_out held for 5 cycles");

        // Reset during the 4th CONV cycle of 124.
        bus.in_valid = 1'b1;
        bus.bcd_in   = 12'h124;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_in_ready", 32'(bus.in_ready), 32'd0);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_bin_out", 32'(bus.bin_out), 32'd0);
        check("abort_ovf", 32'(bus.ovf), 32'd0);
        check("abort_err", 32'(bus.err_digit), 32'd0);
        @(negedge clk);
        check("abort_ready_back", 32'(bus.in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 14; i++) begin
            if (bus.out_valid === 1'b1) seen++;
            @(negedge clk);
        end
        check("abort_no_result", 32'(seen), 32'd0);
        $display("abort bcd=124 reset in conversion, no result emitted");
        run_conv(12'h235, 8'd235, 1'b0, 1'b0, 11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/bcd2binary_seq.md
Name: bcd2binary_seq

Overview:
- Sequential packed-BCD to binary converter. It performs the inverse of the team's combinational Binary2BCD block.
- Uses reverse double-dabble: shift right one bit per cycle; any BCD digit >= 8 after the shift has 3 subtracted.
- Sits behind the decimal-entry front end and feeds 8-bit byte values into the AES key/data path.
- Valid/ready handshake on both sides.

Parameters:
- DIGITS, 3, number of BCD digits on bcd_in (bcd_in is 4*DIGITS bits wide).
- BIN_W, 8, width of bin_out; converted values above 2**BIN_W-1 raise ovf.
- Derived localparam SHIFTS = $clog2(10**DIGITS), which is 10 at the defaults. This is the number of conversion cycles.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  bcd_in is valid
- in_ready  output  1  block can accept a new operand
- bcd_in  input  4*DIGITS  packed BCD; digit 0 is bcd_in[3:0]
- out_valid  output  1  result is valid
- out_ready  input  1  consumer accepts the result
- bin_out  output  BIN_W  binary result
- ovf  output  1  value exceeds 2**BIN_W-1
- err_digit  output  1  at least one input nibble is greater than 9

Behaviour:
- Reset is synchronous and active-high; it is sampled only on the rising edge of clk. While reset is high:
  - state goes to IDLE;
  - in_ready=0, out_valid=0, bin_out=0, ovf=0, err_digit=0;
  - in_ready rises in the first cycle after reset deasserts.
- Reset mid-conversion or mid-DONE aborts the operation. No result is emitted.
- FSM has three states: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch bcd_in into bcd_reg, clear shift-out register bin_reg (SHIFTS bits), and load cnt=SHIFTS.
  - If any nibble is greater than 9: set err_digit=1, bin_out=0, ovf=0, and go directly to DONE. The result is visible on the next edge (latency 1).
  - Otherwise go to CONV.
- CONV:
  - in_ready=0.
  - Each cycle: {bcd_reg,bin_reg} shifts right by 1. Then, for each digit of bcd_reg, if digit>=8 the digit becomes digit-3 (all digits in parallel, same cycle). cnt decrements.
  - When cnt reaches 1, the final shift is performed and the state goes to DONE.
  - On entry to DONE, bin_out is taken from bin_reg (see ovf rules) and out_valid=1.
  - Accept-to-out_valid latency is exactly SHIFTS+1 edges (11 at the defaults).
- DONE:
  - out_valid=1, in_ready=0.
  - bin_out, ovf and err_digit are held stable until out_valid&&out_ready.
  - The handshake returns the block to IDLE. Results are never dropped.
  - There is no same-cycle re-accept: at least one IDLE cycle separates operations.
  - Throughput is one operand per SHIFTS+2 cycles.
- Width and overflow rules:
  - The full result is bin_reg[SHIFTS-1:0].
  - ovf=1 if bin_reg[SHIFTS-1:BIN_W] != 0.
  - Without BCD2BIN_SATURATE_EN: bin_out = bin_reg[BIN_W-1:0] (truncated).
- err_digit and ovf are mutually exclusive. err_digit takes priority.
- in_valid is ignored outside IDLE.
- bcd_in need not be held after acceptance.

Optional Feature:
- Macro: BCD2BIN_SATURATE_EN.
- When defined: on ovf=1, bin_out = all ones (2**BIN_W-1). ovf is still asserted.
- When undefined: bin_out is the truncated low BIN_W bits.
- err_digit behaviour is identical in both builds (bin_out=0).

Decomposition:
- Shared package bcd_pkg holds:
  - the state encoding typedef (IDLE=2'd0, CONV=2'd1, DONE=2'd2);
  - constants BCD_DIGIT_W=4 and BCD_MAX_DIGIT=9;
  - function for the SHIFTS computation.
- One natural sub-module: bcd_digit_adj. It is combinational, 4 bits in / 4 bits out: output = in>=8 ? in-3 : in. It is instantiated DIGITS times with a generate loop.
- The top level keeps the FSM, the counter and the shift registers.

Test Plan:
- bcd_in=12'h251, out_ready=1. Expect out_valid exactly 11 cycles after accept, bin_out=8'd251, ovf=0, err_digit=0.
- Sweep of 12'h000, 12'h001, 12'h255, 12'h100. Expect bin_out 0, 1, 255, 100, each with ovf=0.
- bcd_in=12'h256 and bcd_in=12'h999. Expect ovf=1.
  - Default build: bin_out=8'd0 and 8'd231 (999 mod 256).
  - With BCD2BIN_SATURATE_EN: bin_out=8'hFF for both.
- bcd_in=12'h1A2. Expect err_digit=1, bin_out=0, out_valid on the next edge after accept, no CONV cycles.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - bin_out must stay stable and in_ready must stay 0; a new in_valid during this time must be ignored.
  - Release out_ready: in_ready=1 in the following cycle.
- Assert reset for 1 cycle at the 4th CONV cycle of 12'h124.
  - Expect all outputs 0 next cycle and no out_valid pulse.
  - A subsequent 12'h235 must return 235.
